// File: rtl/mips_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// lane widths and small op-classification helpers.
package mips_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } lsu_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } lsu_state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Word ops need addr[1:0]=00, half ops need addr[0]=0, bytes always fit.
    function automatic logic is_aligned(lsu_op_e op, logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo == 2'b00;
            OP_LH, OP_LHU, OP_SH: return !lo[0];
            default:              return 1'b1;
        endcase
    endfunction

    function automatic logic is_load(lsu_op_e op);
        return (op != OP_SW) && (op != OP_SH) && (op != OP_SB);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load result from the
// read word, and merges a byte/halfword store into a captured word.
module lsu_align
    import mips_pkg::*;
(
    input  logic [2:0]        ld_op,
    input  logic [1:0]        ld_lo,
    input  logic [WORD_W-1:0] ld_word,
    input  logic [2:0]        st_op,
    input  logic [1:0]        st_lo,
    input  logic [WORD_W-1:0] st_word,
    input  logic [HALF_W-1:0] st_wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged_word
);

    logic [HALF_W-1:0] ld_lane;
    logic [WORD_W-1:0] st_mask;
    logic [WORD_W-1:0] st_data;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    always_comb begin
        ld_lane   = HALF_W'(ld_word >> {ld_lo, 3'b000});
        load_data = '0;
        case (lsu_op_e'(ld_op))
            OP_LW:   load_data = ld_word;
            OP_LH:   load_data = {{(WORD_W-HALF_W){ld_lane[HALF_W-1]}}, ld_lane};
            OP_LHU:  load_data = {{(WORD_W-HALF_W){1'b0}}, ld_lane};
            OP_LB:   load_data = {{(WORD_W-BYTE_W){ld_lane[BYTE_W-1]}}, ld_lane[BYTE_W-1:0]};
            OP_LBU:  load_data = {{(WORD_W-BYTE_W){1'b0}}, ld_lane[BYTE_W-1:0]};
            default: load_data = '0;
        endcase
    end

    // Replace only the addressed byte or halfword lane of the captured word.
    always_comb begin
        st_mask = '0;
        st_data = '0;
        case (lsu_op_e'(st_op))
            OP_SB: begin
                st_mask = {{(WORD_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << {st_lo, 3'b000};
                st_data = {{(WORD_W-BYTE_W){1'b0}}, st_wdata[BYTE_W-1:0]} << {st_lo, 3'b000};
            end
            OP_SH: begin
                st_mask = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}} << {st_lo[1], 4'b0000};
                st_data = {{(WORD_W-HALF_W){1'b0}}, st_wdata} << {st_lo[1], 4'b0000};
            end
            default: begin
                st_mask = '0;
                st_data = '0;
            end
        endcase
        merged_word = (st_word & ~st_mask) | st_data;
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Loads and word stores finish in one cycle;
// byte/halfword stores do a read-modify-write, stalling for one cycle.
module load_store_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              misalign,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data
);

    lsu_state_e        state;
    logic [WORD_W-1:0] cap_word;
    logic [ADDR_W-1:0] cap_addr;
    logic [HALF_W-1:0] cap_wdata;
    lsu_op_e           cap_op;

    lsu_op_e           op;
    logic              aligned;
    logic              accept;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] merged_word;

    assign op      = lsu_op_e'(req_op);
    assign aligned = is_aligned(op, req_addr[1:0]);
    assign accept  = (state == ST_IDLE) && req_valid && aligned;

    lsu_align u_align (
        .ld_op       (req_op),
        .ld_lo       (req_addr[1:0]),
        .ld_word     (mem_rd_data),
        .st_op       (cap_op),
        .st_lo       (cap_addr[1:0]),
        .st_word     (cap_word),
        .st_wdata    (cap_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Memory-side controls for the current cycle; reset silences everything at once.
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        stall       = 1'b0;
        mem_addr    = {req_addr[ADDR_W-1:2], 2'b00};
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_load(op)) begin
                            mem_rd_en = 1'b1;
                        end else if (op == OP_SW) begin
                            mem_wr_en   = 1'b1;
                            mem_wr_data = req_wdata;
                        end else begin
                            mem_rd_en = 1'b1;
                            stall     = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = merged_word;
                    mem_addr    = {cap_addr[ADDR_W-1:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

    // FSM, capture registers and registered response/fault outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            misalign   <= 1'b0;
            err_addr   <= '0;
            cap_word   <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_op     <= OP_LW;
        end else begin
            resp_valid <= 1'b0;
            misalign   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!aligned) begin
                            misalign <= 1'b1;
                            err_addr <= req_addr;
                        end else if (is_load(op)) begin
                            resp_valid <= 1'b1;
                            resp_data  <= load_data;
                        end else if (op == OP_SW) begin
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            cap_word  <= mem_rd_data;
                            cap_addr  <= req_addr;
                            cap_wdata <= req_wdata[HALF_W-1:0];
                            cap_op    <= op;
                            state     <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b1;
                    resp_data  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of req_addr, mem_addr and err_addr.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  pipeline MEM-stage request present.
REQ-006 req_op  in  3  encoding: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-007 req_addr  in  ADDR_W  byte address.
REQ-008 req_wdata  in  32  store data, right-justified.
REQ-009 stall  out  1  pipeline SHALL hold req_* unchanged while high.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_data  out  32  load result; 0 for stores.
REQ-012 misalign  out  1  one-cycle alignment-fault pulse.
REQ-013 err_addr  out  ADDR_W  address of the last faulting request.
REQ-014 mem_addr  out  ADDR_W  data-memory address (word-aligned, addr[1:0] forced 00).
REQ-015 mem_rd_en  out  1  data-memory read enable (memory read is combinational).
REQ-016 mem_wr_en  out  1  data-memory write enable (memory writes on the rising edge).
REQ-017 mem_wr_data  out  32  data-memory write word.
REQ-018 mem_rd_data  in  32  data-memory read word.

Function
REQ-019 SHALL use a two-state FSM:
- IDLE: accepts a request when req_valid=1.
- WRITE: second cycle of a sub-word store.
REQ-020 Alignment rules:
- Aligned: word ops addr[1:0]=00; half ops addr[0]=0; byte ops always aligned.
- Misaligned request: no mem enables; misalign=1 and err_addr=req_addr in the next cycle; no resp_valid; stall=0.
REQ-021 Byte lanes SHALL be little-endian: byte n = bits [8n+7:8n]; halfword lane = addr[1].
REQ-022 Loads (1-cycle latency):
- Accept cycle: mem_rd_en=1.
- Next cycle: resp_valid=1 and resp_data registered.
- LH/LB sign-extend; LHU/LBU zero-extend.
REQ-023 SW: mem_wr_en=1 with mem_wr_data=req_wdata in the accept cycle; resp_valid next cycle; stall=0.
REQ-024 SH/SB read-modify-write:
- Accept cycle: mem_rd_en=1, stall=1; capture mem_rd_data, addr, wdata and op; go to WRITE.
REQ-025 In WRITE:
- Drive mem_wr_en=1 with the captured word, replacing only the addressed lane (SB: wdata[7:0]; SH: wdata[15:0]); stall=0.
- Return to IDLE; resp_valid=1 the following cycle.
REQ-026 In WRITE, req_* SHALL be ignored (the held request retires as stall drops); a new request is accepted only in IDLE.
REQ-027 mem_rd_en and mem_wr_en SHALL never both be 1 in the same cycle.
REQ-028 With req_valid=0 in IDLE: all mem enables 0, stall=0.

Reset
REQ-029 Reset SHALL override all activity and, in the same cycle, force mem_rd_en=0, mem_wr_en=0 and stall=0.
REQ-030 After a reset edge:
- state=IDLE.
- resp_valid=0, misalign=0.
- resp_data=0, err_addr=0.
- capture registers=0.
REQ-031 Reset while in WRITE SHALL abandon the pending write; memory is unmodified by this block.

Structure
REQ-032 Op encodings, the FSM state encoding and lane-width constants SHALL live in shared package mips_pkg.
REQ-033 Load extraction, sign/zero extension and store lane merge SHALL be a combinational sub-module lsu_align, instantiated once.

Verification
REQ-034 Scenario: SW 0x0000_0010 data 0xDEADBEEF, then LW 0x10. Required: mem_wr_en for 1 cycle; LW resp_data=0xDEADBEEF one cycle after accept.
REQ-035 Scenario: word 0x11223344 at 0x20; SB 0x21 data 0xAA. Required: stall high 1 cycle, then write of 0x1122AA44; LBU 0x21 returns 0x000000AA; LB 0x21 returns 0xFFFFFFAA.
REQ-036 Scenario: SH 0x22 data 0x8001 over word 0x1122AA44. Required: write 0x8001AA44; LH 0x22 returns 0xFFFF8001; LHU 0x22 returns 0x00008001.
REQ-037 Scenario: LW 0x13, then SH 0x15. Required: no mem enables; misalign pulses with err_addr=0x13, then with err_addr=0x15; no resp_valid.
REQ-038 Scenario: SB accepted, reset asserted in the WRITE cycle. Required: mem_wr_en=0; memory word unchanged; state IDLE; all outputs at reset values.
REQ-039 Scenario: back-to-back SB 0x30 and LW 0x30 with req_valid held continuously. Required: the LW is accepted only after WRITE, and returns the merged word.
